// File: rtl/if_stage_fetch_if.sv
// rtl/if_stage_fetch_if.sv - instruction memory bus between fetch stage and imem
// Purpose: groups the fetch-side instruction memory address/data pair.
// Signals:
//   addr   32  byte address driven by the fetch stage (master)
//   rdata  32  instruction word returned combinationally by memory (slave)
interface if_stage_fetch_if;
  logic [31:0] addr;
  logic [31:0] rdata;

  modport master (output addr, input rdata);
  modport slave  (input addr, output rdata);
endinterface

// File: rtl/if_stage_fetch.sv
// rtl/if_stage_fetch.sv - MIPS instruction-fetch stage with PC and IF/ID register
// Purpose: owns the PC, addresses instruction memory, and registers the fetched
// word into IF/ID under redirect > flush > stall > normal priority.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   stall, flush         hazard controls from downstream
//   redirect, redirect_pc taken branch/jump target
//   imem                 instruction memory bus (master: addr out, rdata in)
//   pc                   current fetch PC
//   if_id_instr/pc/pc4   registered instruction, its PC and PC+4
//   if_id_valid          1 = real instruction, 0 = bubble
//   misalign_err         sticky flag for an accepted unaligned redirect target
//   fetch_count          number of instructions loaded into IF/ID
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  if_stage_fetch_if.master         imem,
  output logic [31:0]              pc,
  output logic [31:0]              if_id_instr,
  output logic [31:0]              if_id_pc,
  output logic [31:0]              if_id_pc4,
  output logic                     if_id_valid,
  output logic                     misalign_err,
  output logic [31:0]              fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        misalign_err_q, misalign_err_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

  // 32-bit modulo increment; wrap past 0xFFFF_FFFC is intentional and silent
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d           = pc_q;
    if_id_instr_d  = if_id_instr_q;
    if_id_pc_d     = if_id_pc_q;
    if_id_pc4_d    = if_id_pc4_q;
    if_id_valid_d  = if_id_valid_q;
    misalign_err_d = misalign_err_q;
    fetch_count_d  = fetch_count_q;

    if (redirect) begin
      // target is forced word aligned; the low bits only raise the sticky flag
      pc_d          = {redirect_pc[31:2], 2'b00};
      if_id_instr_d = NOP_INSTR;
      if_id_pc_d    = 32'h0;
      if_id_pc4_d   = 32'h0;
      if_id_valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err_d = 1'b1;
      end
    end else if (flush) begin
      // bubble fields match reset values so decode sees a clean NOP
      if_id_instr_d = NOP_INSTR;
      if_id_pc_d    = 32'h0;
      if_id_pc4_d   = 32'h0;
      if_id_valid_d = 1'b0;
      if (!stall) begin
        pc_d = pc_plus4;
      end
    end else if (!stall) begin
      pc_d          = pc_plus4;
      if_id_instr_d = imem.rdata;
      if_id_pc_d    = pc_q;
      if_id_pc4_d   = pc_plus4;
      if_id_valid_d = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      if_id_instr_q  <= NOP_INSTR;
      if_id_pc_q     <= 32'h0;
      if_id_pc4_q    <= 32'h0;
      if_id_valid_q  <= 1'b0;
      misalign_err_q <= 1'b0;
      fetch_count_q  <= 32'h0;
    end else begin
      pc_q           <= pc_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_pc_q     <= if_id_pc_d;
      if_id_pc4_q    <= if_id_pc4_d;
      if_id_valid_q  <= if_id_valid_d;
      misalign_err_q <= misalign_err_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  assign imem.addr    = pc_q;
  assign pc           = pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_pc4    = if_id_pc4_q;
  assign if_id_valid  = if_id_valid_q;
  assign misalign_err = misalign_err_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// tb/tb_if_stage_fetch.sv - directed self-checking bench for if_stage_fetch
module tb_if_stage_fetch;
  logic        clk;
  logic        reset, stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc, if_id_instr, if_id_pc, if_id_pc4, fetch_count;
  logic        if_id_valid, misalign_err;

  logic        reset2, stall2, flush2, redirect2;
  logic [31:0] redirect_pc2;
  logic [31:0] pc2, if_id_instr2, if_id_pc2, if_id_pc42, fetch_count2;
  logic        if_id_valid2, misalign_err2;

  int tests;
  int failed;

  if_stage_fetch_if imem ();
  if_stage_fetch_if imem2 ();

  // instruction memory model: word = address ^ 0xA5A5_0000
  assign imem.rdata  = imem.addr ^ 32'hA5A5_0000;
  assign imem2.rdata = imem2.addr ^ 32'hA5A5_0000;

  if_stage_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem(imem),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  if_stage_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset2), .stall(stall2), .flush(flush2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .imem(imem2),
    .pc(pc2), .if_id_instr(if_id_instr2), .if_id_pc(if_id_pc2),
    .if_id_pc4(if_id_pc42), .if_id_valid(if_id_valid2),
    .misalign_err(misalign_err2), .fetch_count(fetch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    tests++; if (pc !== 32'h0) begin failed++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    tests++; if (if_id_instr !== 32'h0) begin failed++; $display("FAIL reset_instr got %h exp %h", if_id_instr, 32'h0); end
    tests++; if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin failed++; $display("FAIL reset_ifid_pc got %h/%h exp 0/0", if_id_pc, if_id_pc4); end
    tests++; if (if_id_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
    tests++; if (misalign_err !== 1'b0 || fetch_count !== 32'h0) begin failed++; $display("FAIL reset_err_cnt got %b/%h exp 0/0", misalign_err, fetch_count); end
    tests++; if (imem.addr !== 32'h0) begin failed++; $display("FAIL reset_imem_addr got %h exp %h", imem.addr, 32'h0); end
    reset = 1'b0;
  endtask

  task automatic test_normal();
    step();
    tests++; if (pc !== 32'h4 || if_id_instr !== 32'hA5A5_0000) begin failed++; $display("FAIL normal_first got pc=%h instr=%h exp 4/a5a50000", pc, if_id_instr); end
    step();
    step();
    tests++; if (pc !== 32'hC) begin failed++; $display("FAIL normal_pc got %h exp %h", pc, 32'hC); end
    tests++; if (imem.addr !== 32'hC) begin failed++; $display("FAIL normal_imem_addr got %h exp %h", imem.addr, 32'hC); end
    tests++; if (if_id_pc !== 32'h8) begin failed++; $display("FAIL normal_ifid_pc got %h exp %h", if_id_pc, 32'h8); end
    tests++; if (if_id_pc4 !== 32'hC) begin failed++; $display("FAIL normal_ifid_pc4 got %h exp %h", if_id_pc4, 32'hC); end
    tests++; if (if_id_instr !== 32'hA5A5_0008) begin failed++; $display("FAIL normal_instr got %h exp %h", if_id_instr, 32'hA5A5_0008); end
    tests++; if (if_id_valid !== 1'b1) begin failed++; $display("FAIL normal_valid got %b exp 1", if_id_valid); end
    tests++; if (fetch_count !== 32'd3) begin failed++; $display("FAIL normal_count got %0d exp 3", fetch_count); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    step();
    step();
    tests++; if (pc !== 32'hC) begin failed++; $display("FAIL stall_pc got %h exp %h", pc, 32'hC); end
    tests++; if (if_id_pc !== 32'h8 || if_id_instr !== 32'hA5A5_0008) begin failed++; $display("FAIL stall_ifid got pc=%h instr=%h exp 8/a5a50008", if_id_pc, if_id_instr); end
    tests++; if (fetch_count !== 32'd3) begin failed++; $display("FAIL stall_count got %0d exp 3", fetch_count); end
    stall = 1'b0;
    step();
    tests++; if (if_id_pc !== 32'hC || pc !== 32'h10) begin failed++; $display("FAIL stall_release got ifid_pc=%h pc=%h exp c/10", if_id_pc, pc); end
    tests++; if (fetch_count !== 32'd4) begin failed++; $display("FAIL stall_release_count got %0d exp 4", fetch_count); end
  endtask

  task automatic test_redirect_priority();
    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1; flush = 1'b1;
    step();
    redirect = 1'b0; stall = 1'b0; flush = 1'b0;
    tests++; if (pc !== 32'h40) begin failed++; $display("FAIL redir_pc got %h exp %h", pc, 32'h40); end
    tests++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin failed++; $display("FAIL redir_bubble got valid=%b instr=%h exp 0/0", if_id_valid, if_id_instr); end
    tests++; if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin failed++; $display("FAIL redir_bubble_pc got %h/%h exp 0/0", if_id_pc, if_id_pc4); end
    tests++; if (fetch_count !== 32'd4 || misalign_err !== 1'b0) begin failed++; $display("FAIL redir_cnt_err got %0d/%b exp 4/0", fetch_count, misalign_err); end
    step();
    tests++; if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1 || pc !== 32'h44) begin failed++; $display("FAIL redir_next got ifid_pc=%h valid=%b pc=%h exp 40/1/44", if_id_pc, if_id_valid, pc); end
    tests++; if (if_id_instr !== 32'hA5A5_0040 || fetch_count !== 32'd5) begin failed++; $display("FAIL redir_next_instr got %h/%0d exp a5a50040/5", if_id_instr, fetch_count); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    tests++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0) begin failed++; $display("FAIL flush_bubble got valid=%b instr=%h pc=%h exp 0/0/0", if_id_valid, if_id_instr, if_id_pc); end
    tests++; if (pc !== 32'h48) begin failed++; $display("FAIL flush_pc got %h exp %h", pc, 32'h48); end
    tests++; if (fetch_count !== 32'd5) begin failed++; $display("FAIL flush_count got %0d exp 5", fetch_count); end
    stall = 1'b1;
    step();
    tests++; if (pc !== 32'h48 || if_id_valid !== 1'b0) begin failed++; $display("FAIL flush_stall got pc=%h valid=%b exp 48/0", pc, if_id_valid); end
    tests++; if (fetch_count !== 32'd5) begin failed++; $display("FAIL flush_stall_count got %0d exp 5", fetch_count); end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    tests++; if (pc !== 32'h40) begin failed++; $display("FAIL misalign_pc got %h exp %h", pc, 32'h40); end
    tests++; if (misalign_err !== 1'b1) begin failed++; $display("FAIL misalign_set got %b exp 1", misalign_err); end
    for (int i = 0; i < 5; i++) step();
    tests++; if (misalign_err !== 1'b1) begin failed++; $display("FAIL misalign_sticky got %b exp 1", misalign_err); end
    tests++; if (pc !== 32'h54 || fetch_count !== 32'd10) begin failed++; $display("FAIL misalign_run got pc=%h cnt=%0d exp 54/10", pc, fetch_count); end
    reset = 1'b1;
    #1;
    tests++; if (misalign_err !== 1'b0 || pc !== 32'h0 || fetch_count !== 32'h0) begin failed++; $display("FAIL misalign_reset got err=%b pc=%h cnt=%0d exp 0/0/0", misalign_err, pc, fetch_count); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    tests++; if (pc2 !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_reset_pc got %h exp %h", pc2, 32'hFFFF_FFFC); end
    reset2 = 1'b0;
    step();
    tests++; if (pc2 !== 32'h0 || if_id_pc42 !== 32'h0) begin failed++; $display("FAIL wrap_pc got pc=%h pc4=%h exp 0/0", pc2, if_id_pc42); end
    tests++; if (if_id_pc2 !== 32'hFFFF_FFFC || if_id_instr2 !== 32'h5A5A_FFFC) begin failed++; $display("FAIL wrap_ifid got pc=%h instr=%h exp fffffffc/5a5afffc", if_id_pc2, if_id_instr2); end
    tests++; if (if_id_valid2 !== 1'b1 || misalign_err2 !== 1'b0 || fetch_count2 !== 32'd1) begin failed++; $display("FAIL wrap_flags got valid=%b err=%b cnt=%0d exp 1/0/1", if_id_valid2, misalign_err2, fetch_count2); end
    step();
    tests++; if (pc2 !== 32'h4) begin failed++; $display("FAIL wrap_next_pc got %h exp %h", pc2, 32'h4); end
    reset2 = 1'b1;
    #2;
    tests++; if (pc2 !== 32'hFFFF_FFFC || if_id_instr2 !== 32'h0 || if_id_pc2 !== 32'h0 || if_id_pc42 !== 32'h0) begin failed++; $display("FAIL wrap_async_reset got pc=%h instr=%h ipc=%h pc4=%h", pc2, if_id_instr2, if_id_pc2, if_id_pc42); end
    tests++; if (if_id_valid2 !== 1'b0 || fetch_count2 !== 32'h0 || misalign_err2 !== 1'b0) begin failed++; $display("FAIL wrap_async_reset_flags got valid=%b cnt=%0d err=%b exp 0/0/0", if_id_valid2, fetch_count2, misalign_err2); end
  endtask

  initial begin
    tests = 0; failed = 0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    reset2 = 1'b1; stall2 = 1'b0; flush2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0;
    test_reset();
    test_normal();
    test_stall();
    test_redirect_priority();
    test_flush();
    test_misalign();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
